// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with per-entry pending
// scoreboard, write-through bypass and a sequential clear engine.
module regfile_sb #(
  parameter int N     = 2,
  parameter int M     = 4,
  parameter int NR    = 2,
  parameter int ZERO0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [N-1:0]      a3,
  input  logic [M-1:0]      d3,
  input  logic [NR*N-1:0]   ra,
  output logic [NR*M-1:0]   rd,
  output logic [NR-1:0]     rdy,
  input  logic              iss,
  input  logic [N-1:0]      ia,
  output logic [2**N-1:0]   pend,
  input  logic              clr,
  output logic              busy
);

  localparam int unsigned D = 2**N;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] cnt;
  logic [M-1:0] mem [D];

  logic z_a3;
  logic z_ia;
  logic byp;
  logic wen;
  logic iss_ok;

  assign z_a3   = (ZERO0 != 0) && (a3 == '0);
  assign z_ia   = (ZERO0 != 0) && (ia == '0);
  // bypass is visible whenever a write is presented in IDLE; a
  // simultaneous clr only suppresses the array update itself
  assign byp    = we3 && !busy && !z_a3;
  assign wen    = byp && !clr;
  assign iss_ok = iss && !busy && !z_ia;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state and busy decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (clr) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // clear-sweep counter: loaded on entry, stepped once per CLEAR cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (state == IDLE && clr)  cnt <= '0;
    else if (state == CLEAR)        cnt <= cnt + 1'b1;
  end

  // storage array: clear sweep has priority over normal writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < D; i++) mem[N'(i)] <= '0;
    end else if (busy) begin
      mem[cnt] <= '0;
    end else if (wen) begin
      mem[a3] <= d3;
    end
  end

  // pending bits: write clears, issue sets afterwards so set wins on collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if (busy) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (wen)    pend[a3] <= 1'b0;
      if (iss_ok) pend[ia] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [N-1:0] addr;
    logic [M-1:0] rd_g;
    logic         rdy_g;

    assign addr = ra[g*N +: N];

    // combinational read with write-through bypass and hardwired zero entry
    always_comb begin
      rd_g  = mem[addr];
      rdy_g = ~pend[addr];
      if (byp && (a3 == addr)) begin
        rd_g  = d3;
        rdy_g = 1'b1;
      end
      if ((ZERO0 != 0) && (addr == '0)) begin
        rd_g  = '0;
        rdy_g = 1'b1;
      end
    end

    assign rd[g*M +: M] = rd_g;
    assign rdy[g]       = rdy_g;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb (default and ZERO0=1).
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic       we3, iss, clr, busy;
  logic [1:0] a3, ia, rdy;
  logic [3:0] d3, ra, pend;
  logic [7:0] rd;

  logic       z_we3, z_iss, z_clr, z_busy;
  logic [1:0] z_a3, z_ia, z_rdy;
  logic [3:0] z_d3, z_ra, z_pend;
  logic [7:0] z_rd;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  regfile_sb #(.N(2), .M(4), .NR(2), .ZERO0(0)) dut (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .d3(d3), .ra(ra), .rd(rd),
    .rdy(rdy), .iss(iss), .ia(ia), .pend(pend), .clr(clr), .busy(busy)
  );

  regfile_sb #(.N(2), .M(4), .NR(2), .ZERO0(1)) dut_z (
    .clk(clk), .reset(reset), .we3(z_we3), .a3(z_a3), .d3(z_d3), .ra(z_ra), .rd(z_rd),
    .rdy(z_rdy), .iss(z_iss), .ia(z_ia), .pend(z_pend), .clr(z_clr), .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we3 = 1'b0; iss = 1'b0; clr = 1'b0; a3 = '0; ia = '0; d3 = '0;
    z_we3 = 1'b0; z_iss = 1'b0; z_clr = 1'b0; z_a3 = '0; z_ia = '0; z_d3 = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    ra = '0; z_ra = '0;
    repeat (2) tick();
    reset = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'b11);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL reset_pend: got %h expected %h", pend, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rdy) !== e) begin errors++; $display("FAIL reset_rdy: got %b expected %b", rdy, e[1:0]); end
    for (int a = 0; a < 4; a++) begin
      ra = {2'(3 - a), 2'(a)};
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL reset_rd0[%0d]: got %h expected %h", a, rd[3:0], e); end
      e = exp_q.pop_front(); checks++;
      if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL reset_rd1[%0d]: got %h expected %h", 3 - a, rd[7:4], e); end
    end
  endtask

  task automatic test_write_read;
    we3 = 1'b1; a3 = 2'd2; d3 = 4'hA;
    tick();
    we3 = 1'b0;
    ra = {2'd0, 2'd2};
    exp_q.push_back(32'hA);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL wr_rd0: got %h expected %h", rd[3:0], e); end
    we3 = 1'b1; a3 = 2'd2; d3 = 4'h5; ra = {2'd2, 2'd2};
    exp_q.push_back(32'h5);
    exp_q.push_back(32'h5);
    exp_q.push_back(32'b11);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL bypass_rd1: got %h expected %h", rd[7:4], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL bypass_rd0: got %h expected %h", rd[3:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rdy) !== e) begin errors++; $display("FAIL bypass_rdy: got %b expected %b", rdy, e[1:0]); end
    tick();
    we3 = 1'b1; a3 = 2'd1; d3 = 4'hC;
    tick();
    we3 = 1'b0;
    ra = {2'd1, 2'd2};
    exp_q.push_back(32'h5);
    exp_q.push_back(32'hC);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL stored_rd0: got %h expected %h", rd[3:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL stored_rd1: got %h expected %h", rd[7:4], e); end
  endtask

  task automatic test_scoreboard;
    iss = 1'b1; ia = 2'd1;
    tick();
    iss = 1'b0;
    ra = {2'd2, 2'd1};
    exp_q.push_back(32'b0010);
    exp_q.push_back(32'b10);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL sb_pend_set: got %b expected %b", pend, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(rdy) !== e) begin errors++; $display("FAIL sb_rdy_pending: got %b expected %b", rdy, e[1:0]); end
    we3 = 1'b1; a3 = 2'd1; d3 = 4'h3;
    exp_q.push_back(32'b11);
    exp_q.push_back(32'h3);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(rdy) !== e) begin errors++; $display("FAIL sb_rdy_bypass: got %b expected %b", rdy, e[1:0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL sb_rd_bypass: got %h expected %h", rd[3:0], e); end
    tick();
    we3 = 1'b0;
    exp_q.push_back(32'b0000);
    exp_q.push_back(32'h3);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL sb_pend_clr: got %b expected %b", pend, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL sb_rd_stored: got %h expected %h", rd[3:0], e); end
  endtask

  task automatic test_collision;
    iss = 1'b1; ia = 2'd3; we3 = 1'b1; a3 = 2'd3; d3 = 4'h7;
    tick();
    idle_inputs();
    ra = {2'd3, 2'd3};
    exp_q.push_back(32'h7);
    exp_q.push_back(32'b1000);
    exp_q.push_back(32'b00);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL coll_rd: got %h expected %h", rd[3:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL coll_pend: got %b expected %b", pend, e[3:0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(rdy) !== e) begin errors++; $display("FAIL coll_rdy: got %b expected %b", rdy, e[1:0]); end
  endtask

  task automatic test_clear;
    for (int a = 0; a < 4; a++) begin
      we3 = 1'b1; a3 = 2'(a); d3 = 4'(a + 1);
      tick();
    end
    we3 = 1'b0;
    clr = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      we3 = 1'b1; a3 = 2'(k); d3 = 4'hF; iss = 1'b1; ia = 2'd2; clr = (k < 2);
      ra = {2'd3, 2'(k)};
      exp_q.push_back(32'd1);
      exp_q.push_back(32'(k + 1));
      exp_q.push_back(32'd4);
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(busy) !== e) begin errors++; $display("FAIL clr_busy[%0d]: got %b expected %b", k, busy, e[0]); end
      e = exp_q.pop_front(); checks++;
      if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL clr_partial_rd0[%0d]: got %h expected %h", k, rd[3:0], e); end
      e = exp_q.pop_front(); checks++;
      if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL clr_partial_rd1[%0d]: got %h expected %h", k, rd[7:4], e); end
      tick();
    end
    idle_inputs();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'b0000);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL clr_done_busy: got %b expected %b", busy, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL clr_done_pend: got %b expected %b", pend, e[3:0]); end
    for (int a = 0; a < 4; a++) begin
      ra = {2'(a), 2'(a)};
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL clr_done_rd[%0d]: got %h expected %h", a, rd[3:0], e); end
    end
  endtask

  task automatic test_back_to_back;
    clr = 1'b1;
    tick();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL b2b_enter: got %b expected %b", busy, e[0]); end
    repeat (3) tick();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL b2b_last: got %b expected %b", busy, e[0]); end
    tick();
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL b2b_idle_gap: got %b expected %b", busy, e[0]); end
    tick();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL b2b_reenter: got %b expected %b", busy, e[0]); end
    clr = 1'b0;
    repeat (4) tick();
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL b2b_done: got %b expected %b", busy, e[0]); end
  endtask

  task automatic test_reset_mid_clear;
    for (int a = 0; a < 4; a++) begin
      we3 = 1'b1; a3 = 2'(a); d3 = 4'(9 + a);
      tick();
    end
    we3 = 1'b0;
    iss = 1'b1; ia = 2'd2;
    tick();
    iss = 1'b0;
    exp_q.push_back(32'b0100);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL rmc_pend_pre: got %b expected %b", pend, e[3:0]); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL rmc_busy_pre: got %b expected %b", busy, e[0]); end
    reset = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'b0000);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL rmc_busy_async: got %b expected %b", busy, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(pend) !== e) begin errors++; $display("FAIL rmc_pend_async: got %b expected %b", pend, e[3:0]); end
    for (int p = 0; p < 2; p++) begin
      ra = {2'(2 * p + 1), 2'(2 * p)};
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(rd[3:0]) !== e) begin errors++; $display("FAIL rmc_rd0[%0d]: got %h expected %h", 2 * p, rd[3:0], e); end
      e = exp_q.pop_front(); checks++;
      if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL rmc_rd1[%0d]: got %h expected %h", 2 * p + 1, rd[7:4], e); end
    end
    reset = 1'b0;
    tick();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(busy) !== e) begin errors++; $display("FAIL rmc_busy_after: got %b expected %b", busy, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd[7:4]) !== e) begin errors++; $display("FAIL rmc_rd_after: got %h expected %h", rd[7:4], e); end
  endtask

  task automatic test_zero0;
    z_we3 = 1'b1; z_a3 = 2'd0; z_d3 = 4'hF; z_iss = 1'b1; z_ia = 2'd0;
    z_ra = {2'd1, 2'd0};
    exp_q.push_back(32'd0);
    exp_q.push_back(32'b11);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(z_rd[3:0]) !== e) begin errors++; $display("FAIL z0_rd_nobypass: got %h expected %h", z_rd[3:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(z_rdy) !== e) begin errors++; $display("FAIL z0_rdy: got %b expected %b", z_rdy, e[1:0]); end
    tick();
    idle_inputs();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'b0000);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(z_rd[3:0]) !== e) begin errors++; $display("FAIL z0_rd_stored: got %h expected %h", z_rd[3:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(z_pend) !== e) begin errors++; $display("FAIL z0_pend: got %b expected %b", z_pend, e[3:0]); end
    z_we3 = 1'b1; z_a3 = 2'd1; z_d3 = 4'h6;
    exp_q.push_back(32'h6);
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(z_rd[7:4]) !== e) begin errors++; $display("FAIL z0_entry1_bypass: got %h expected %h", z_rd[7:4], e); end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    test_zero0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Parameters
REQ-001 The block SHALL have parameter N, default 2, meaning address width; depth is 2**N entries.
REQ-002 The block SHALL have parameter M, default 4, meaning data width of each entry.
REQ-003 The block SHALL have parameter NR, default 2, meaning number of read ports (1..8).
REQ-004 The block SHALL have parameter ZERO0, default 0; when 1, entry 0 is hardwired to zero.

Interface
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 we3  input  1  write enable.
REQ-008 a3  input  N  write address.
REQ-009 d3  input  M  write data.
REQ-010 ra  input  NR*N  read addresses; port i at bits [i*N +: N].
REQ-011 rd  output  NR*M  read data; port i at bits [i*M +: M].
REQ-012 rdy  output  NR  port i entry not pending (data valid).
REQ-013 iss  input  1  issue: mark entry ia pending.
REQ-014 ia  input  N  issue address.
REQ-015 pend  output  2**N  pending bit per entry.
REQ-016 clr  input  1  request sequential clear of all entries.
REQ-017 busy  output  1  high while sequential clear in progress.

Function
REQ-018 Writes SHALL occur at the rising clk edge when we3=1 and busy=0: mem[a3] <= d3.
REQ-019 Reads SHALL be combinational, zero latency: rd_i = mem[ra_i].
REQ-020 Write-through bypass: when we3=1, busy=0, a3==ra_i, rd_i SHALL equal d3 in the same cycle.
REQ-021 With ZERO0=1, writes to entry 0 SHALL be dropped, rd_i for ra_i=0 SHALL be 0 (no bypass), pend[0] SHALL stay 0.
REQ-022 iss=1 with busy=0 SHALL set pend[ia] at the next edge.
REQ-023 we3=1 with busy=0 SHALL clear pend[a3] at the next edge.
REQ-024 iss and we3 to the same address in the same cycle: set SHALL win (pend stays 1, data still written).
REQ-025 rdy_i SHALL equal ~pend[ra_i], or 1 when a bypassing write to ra_i is present (REQ-020).
REQ-026 FSM SHALL have states IDLE and CLEAR; busy=1 exactly in CLEAR.
REQ-027 IDLE -> CLEAR on clr=1; an internal N-bit counter SHALL be loaded with 0 on that edge.
REQ-028 In CLEAR, each edge SHALL write 0 to mem[cnt], clear pend[cnt], and increment cnt.
REQ-029 CLEAR -> IDLE on the edge that clears entry 2**N-1; total busy duration SHALL be exactly 2**N cycles.
REQ-030 In CLEAR, we3, iss and clr SHALL be ignored; reads return current (partially cleared) contents, no bypass.
REQ-031 clr and we3 asserted together in IDLE: the write SHALL be dropped; clear starts.
REQ-032 Counter SHALL not wrap into a second pass; clr held high after completion re-enters CLEAR next cycle.

Reset
REQ-033 reset=1 SHALL immediately, without clk, set all mem entries to 0, pend to 0, FSM to IDLE, cnt to 0, busy to 0.
REQ-034 Reset asserted during CLEAR SHALL abort the clear; after deassertion the block is IDLE with all entries 0.
REQ-035 Out of reset, rd=0 on all ports and rdy all 1.

Verification
REQ-036 Write/read: we3=1,a3=2,d3=4'hA, edge; ra port0=2 -> rd0=4'hA; same cycle ra port1=2 with bypass write d3=4'h5 -> rd1=4'h5, rd0 shows 4'h5 too.
REQ-037 Scoreboard: iss=1,ia=1, edge -> pend=4'b0010, rdy for ra=1 =0; then we3=1,a3=1,d3=4'h3 -> rdy=1 same cycle, pend=0 after edge.
REQ-038 Collision: iss=1,ia=3 and we3=1,a3=3,d3=4'h7 same cycle -> mem[3]=4'h7, pend[3]=1.
REQ-039 Clear: fill entries with 1..4, pulse clr -> busy=1 for exactly 4 cycles, writes/iss during busy ignored, all rd=0 and pend=0 after.
REQ-040 Reset mid-clear: assert reset at cycle 2 of CLEAR asynchronously -> busy=0 immediately, all entries 0, pend=0.
REQ-041 ZERO0=1: we3=1,a3=0,d3=4'hF and iss=1,ia=0 -> rd for ra=0 stays 0, pend[0] stays 0.
